// File: rtl/or_bank_pkg.sv
// Shared types and constants for the OR-bank self-test sequencer.
package or_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam logic [1:0] MODE_WALK1 = 2'd0;
  localparam logic [1:0] MODE_WALK0 = 2'd1;
  localparam logic [1:0] MODE_SWEEP = 2'd2;
  localparam logic [1:0] MODE_NULL  = 2'd3;

  localparam int NPAT_WALK1 = 14;
  localparam int NPAT_WALK0 = 14;
  localparam int NPAT_SWEEP = 128;

  localparam logic [7:0] FAIL_NONE = 8'hFF;

  function automatic logic [7:0] last_idx(input logic [1:0] mode);
    case (mode)
      MODE_WALK0: return 8'(NPAT_WALK0 - 1);
      MODE_SWEEP: return 8'(NPAT_SWEEP - 1);
      default:    return 8'(NPAT_WALK1 - 1);
    endcase
  endfunction

endpackage

// File: rtl/or_bank_sequencer_if.sv
// Control, pattern and result bundle between the sequencer and its environment.
interface or_bank_sequencer_if #(
  parameter int IN_W  = 14,
  parameter int LED_W = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [IN_W-1:0]  pat_out;
  logic [LED_W-1:0] led_in;
  logic             busy;
  logic             done;
  logic [7:0]       err_count;
  logic [7:0]       fail_idx;
  logic [LED_W-1:0] first_fail_led;

  modport master (
    input  start, mode, led_in,
    output pat_out, busy, done, err_count, fail_idx, first_fail_led
  );

  modport slave (
    output start, mode, led_in,
    input  pat_out, busy, done, err_count, fail_idx, first_fail_led
  );
endinterface

// File: rtl/or_bank_expect.sv
// Combinational expected-LED model: pair ORs plus the latch shadow.
// Latch bit is masked out of the compare until the shadow has been set once.
module or_bank_expect
  import or_bank_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int LED_W = 8
) (
  input  logic [IN_W-1:0]  i_pat,
  input  logic             i_shadow,
  input  logic             i_shadow_vld,
  output logic [LED_W-1:0] o_exp,
  output logic [LED_W-1:0] o_mask
);

  always_comb begin
    o_exp = '0;
    for (int i = 0; i < LED_W - 1; i++) begin
      o_exp[i] = i_pat[2*i] | i_pat[2*i+1];
    end
    o_exp[LED_W-1] = i_shadow;
    o_mask = {i_shadow_vld, {(LED_W-1){1'b1}}};
  end

endmodule

// File: rtl/or_bank_sequencer.sv
// OR-bank self-test: apply pattern, settle SETTLE cycles, check LEDs; SETTLE+2 cycles per pattern.
// No backpressure; start is only honoured in IDLE and results hold until the next accepted start.
module or_bank_sequencer
  import or_bank_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int LED_W  = 8,
  parameter int SETTLE = 2
) (
  input logic               clk,
  input logic               rst_n,
  or_bank_sequencer_if.master bus
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [7:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_shadow;
  logic             r_shadow_vld;
  logic [IN_W-1:0]  r_pat;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_err;
  logic [7:0]       r_fail;
  logic [LED_W-1:0] r_ffl;

  logic [IN_W-1:0]  w_pat;
  logic [LED_W-1:0] w_exp;
  logic [LED_W-1:0] w_mask;
  logic             w_mismatch;
  logic             w_last;

  always_comb begin
    w_pat = '0;
    case (r_mode)
      MODE_WALK1: w_pat = IN_W'(1) << r_idx;
      MODE_WALK0: w_pat = ~(IN_W'(1) << r_idx);
      MODE_SWEEP: w_pat = IN_W'({r_idx[6:0], r_idx[6:0]});
      default:    w_pat = '0;
    endcase
  end

  // Expected value is built from the registered pattern, i.e. what the bank actually sees.
  or_bank_expect #(
    .IN_W  (IN_W),
    .LED_W (LED_W)
  ) u_expect (
    .i_pat        (r_pat),
    .i_shadow     (r_shadow),
    .i_shadow_vld (r_shadow_vld),
    .o_exp        (w_exp),
    .o_mask       (w_mask)
  );

  assign w_mismatch = |((bus.led_in ^ w_exp) & w_mask);
  assign w_last     = (r_idx == last_idx(r_mode));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_WALK1;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_shadow     <= 1'b0;
      r_shadow_vld <= 1'b0;
      r_pat        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= '0;
      r_fail       <= FAIL_NONE;
      r_ffl        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.mode == MODE_NULL) begin
              r_pat   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_mode       <= bus.mode;
              r_idx        <= '0;
              r_err        <= '0;
              r_fail       <= FAIL_NONE;
              r_ffl        <= '0;
              r_shadow_vld <= 1'b0;
              r_state      <= ST_APPLY;
            end
          end
        end
        ST_APPLY: begin
          r_pat <= w_pat;
          // The bank latch captures the top input bit whenever inputs 0 and 1 are both high.
          if (w_pat[0] & w_pat[1]) begin
            r_shadow     <= w_pat[IN_W-1];
            r_shadow_vld <= 1'b1;
          end
          r_cnt   <= CNT_INIT;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + 8'd1;
            if (r_err == '0) begin
              r_fail <= r_idx;
              r_ffl  <= bus.led_in;
            end
          end
          if (w_last) begin
            r_pat   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= ST_APPLY;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pat_out        = r_pat;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err_count      = r_err;
  assign bus.fail_idx       = r_fail;
  assign bus.first_fail_led = r_ffl;

endmodule

// File: tb/tb_or_bank_sequencer.sv
// Bench for or_bank_sequencer: behavioural OR bank with fault injection and a run-level reference model.
module tb_or_bank_sequencer;

  localparam int IN_W   = 14;
  localparam int LED_W  = 8;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] and_m = 8'hFF;
  logic [7:0] or_m  = 8'h00;
  logic bank_latch = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  or_bank_sequencer_if #(.IN_W(IN_W), .LED_W(LED_W)) bus ();

  or_bank_sequencer #(
    .IN_W   (IN_W),
    .LED_W  (LED_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural OR bank: pair ORs, an unreset latch on bit 7, then stuck-at faults.
  always @(posedge clk) begin
    if (bus.pat_out[0] & bus.pat_out[1]) bank_latch <= bus.pat_out[IN_W-1];
  end

  always_comb begin
    logic [LED_W-1:0] good;
    good = '0;
    for (int i = 0; i < LED_W - 1; i++) good[i] = bus.pat_out[2*i] | bus.pat_out[2*i+1];
    good[LED_W-1] = bank_latch;
    bus.led_in = (good & and_m) | or_m;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ref_pat(input logic [1:0] m, input int idx);
    int c;
    case (m)
      2'd0: return 14'(1 << idx);
      2'd1: return ~14'(1 << idx);
      2'd2: begin
        c = idx % 128;
        return 14'(c * 128 + c);
      end
      default: return 14'd0;
    endcase
  endfunction

  function automatic void ref_run(input logic [1:0] m, input logic [7:0] am, input logic [7:0] om,
                                  input logic l0, output int e_err, output logic [7:0] e_fail,
                                  output logic [7:0] e_ffl, output int e_len, output logic [13:0] e_p1);
    int n;
    logic latch, valid;
    logic [13:0] pat;
    logic [7:0] good, obs, diff;
    n = (m == 2'd2) ? 128 : ((m == 2'd3) ? 0 : 14);
    latch = l0; valid = 1'b0;
    e_err = 0; e_fail = 8'hFF; e_ffl = 8'h00; e_p1 = 14'd0;
    for (int idx = 0; idx < n; idx++) begin
      pat = ref_pat(m, idx);
      if (idx == 1) e_p1 = pat;
      if (pat[0] && pat[1]) begin
        latch = pat[13];
        valid = 1'b1;
      end
      for (int i = 0; i < 7; i++) good[i] = pat[2*i] | pat[2*i+1];
      good[7] = latch;
      obs = (good & am) | om;
      diff = obs ^ good;
      if (!valid) diff[7] = 1'b0;
      if (diff != 8'h00) begin
        if (e_err == 0) begin
          e_fail = 8'(idx);
          e_ffl = obs;
        end
        e_err++;
      end
    end
    e_len = n * (SETTLE + 2) + 1;
  endfunction

  task automatic do_run(input logic [1:0] m, input logic [7:0] am, input logic [7:0] om,
                        input bit mid_start, input string tag);
    int e_err, e_len, cyc;
    logic [7:0] e_fail, e_ffl;
    logic [13:0] e_p1;
    bit busy_ok;
    @(negedge clk);
    and_m = am;
    or_m = om;
    ref_run(m, am, om, bank_latch, e_err, e_fail, e_ffl, e_len, e_p1);
    bus.mode = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode = 2'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (!bus.done && cyc < 2000) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (mid_start) bus.start = (cyc == 10);
      @(posedge clk);
      #1;
      cyc++;
      if (m != 2'd3 && cyc == SETTLE + 4) chk({tag, ".pat_idx1"}, 32'(bus.pat_out), 32'(e_p1));
    end
    bus.start = 1'b0;
    chk({tag, ".run_len"}, 32'(cyc), 32'(e_len));
    chk({tag, ".busy_held"}, {31'd0, busy_ok & bus.busy}, 32'd1);
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(e_err));
    chk({tag, ".fail_idx"}, 32'(bus.fail_idx), 32'(e_fail));
    chk({tag, ".first_fail_led"}, 32'(bus.first_fail_led), 32'(e_ffl));
    chk({tag, ".pat_at_done"}, 32'(bus.pat_out), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    logic [1:0] m;
    logic [7:0] am, om;
    bus.start = 1'b0;
    bus.mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pat_out", 32'(bus.pat_out), 32'd0);
    chk("rst.busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("rst.err_count", 32'(bus.err_count), 32'd0);
    chk("rst.fail_idx", 32'(bus.fail_idx), 32'hFF);
    chk("rst.first_fail_led", 32'(bus.first_fail_led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run(2'd3, 8'hFF, 8'h00, 1'b0, "null");
    do_run(2'd0, 8'hFF, 8'h00, 1'b1, "walk1_clean_midstart");
    do_run(2'd0, 8'hF7, 8'h00, 1'b0, "walk1_led3_low");
    do_run(2'd1, 8'hFF, 8'h80, 1'b0, "walk0_led7_high");
    do_run(2'd2, 8'h00, 8'h00, 1'b0, "sweep_all_low");

    // Reset while idx 5 is settling.
    @(negedge clk);
    and_m = 8'hFF;
    or_m = 8'h00;
    bus.mode = 2'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("midrst.pat_before", 32'(bus.pat_out), 32'(ref_pat(2'd0, 5)));
    rst_n = 1'b0;
    #1;
    chk("midrst.busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("midrst.pat_out", 32'(bus.pat_out), 32'd0);
    chk("midrst.fail_idx", 32'(bus.fail_idx), 32'hFF);
    chk("midrst.err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(2'd0, 8'hFF, 8'h00, 1'b0, "after_reset");

    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 2));
      am = 8'hFF;
      om = 8'h00;
      case ($urandom_range(0, 2))
        1: am = ~(8'd1 << $urandom_range(0, 7));
        2: om = 8'd1 << $urandom_range(0, 7);
        default: ;
      endcase
      do_run(m, am, om, 1'($urandom_range(0, 1)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/or_bank_sequencer.md
# or_bank_sequencer

Self-test controller for the 14-input / 8-LED OR bank: drives the bank's 14-bit input vector through a selectable pattern sequence, holds each pattern for a settle window, samples the bank's LED outputs, and compares them against an internal expected-value model. Sits between the board-level start/mode controls and the OR bank. Reports pass/fail, error count and the first failing pattern so the LED bank can be qualified in place.

## Interface
- IN_W, 14, width of pattern output; must be even, and bank pairs are (2i, 2i+1)
- LED_W, 8, width of LED input; bits 0..LED_W-2 are pair ORs, and bit LED_W-1 is the bank's latch
- SETTLE, 2, cycles a pattern is held before sampling; range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- mode  in  2  0 walking-one, 1 walking-zero, 2 counter sweep, 3 null run
- pat_out  out  IN_W  drives the OR bank input vector
- led_in  in  LED_W  OR bank LED outputs
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at end of run
- err_count  out  8  number of failing patterns in the last run
- fail_idx  out  8  index of the first failing pattern; 8'hFF if none
- first_fail_led  out  LED_W  led_in captured at the first failure

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, FINISH.
- IDLE with start=1:
  - mode 3 goes to FINISH.
  - Otherwise, latch mode, set idx=0, clear err_count, set fail_idx=FF, clear first_fail_led and shadow_valid, go to APPLY.
- APPLY: register pat_out = pattern(mode, idx), update the latch shadow, and go to SETTLE.
- SETTLE: count SETTLE cycles, then go to CHECK.
- CHECK:
  - Compare led_in against the expected vector.
  - On a mismatch, increment err_count. If this is the first failure, also record idx and led_in.
  - If idx is the last pattern, go to FINISH. Otherwise increment idx and go to APPLY.
- FINISH: set pat_out=0, pulse done, go to IDLE.
- Patterns:
  - Mode 0: 1<<idx, idx 0..13.
  - Mode 1: ~(1<<idx), idx 0..13.
  - Mode 2: {c,c} with c=idx[6:0], idx 0..127.
- Expected value:
  - Bit i (i < LED_W-1) is pat[2i] | pat[2i+1].
  - Bit LED_W-1 is the latch shadow.
- Latch shadow: in APPLY, if pat[0]&pat[1], set shadow=pat[IN_W-1] and shadow_valid=1; otherwise hold.
- Bit LED_W-1 is excluded from the compare while shadow_valid=0, because the bank latch has no reset.
- The mode input is ignored after IDLE; the latched copy is used.
- start is ignored while busy.

## Timing
- Reset values: pat_out=0, busy=0, done=0, err_count=0, fail_idx=8'hFF, first_fail_led=0, state IDLE.
- Reset mid-run returns all outputs to their reset values immediately; the next start begins again at idx 0.
- The start edge is sampled at edge k. busy is high from k+1 through the FINISH cycle, and done is high for that same FINISH cycle.
- Per pattern: one APPLY cycle, SETTLE cycles, one CHECK cycle, so SETTLE+2 cycles per pattern.
- Run length from the start edge to the done cycle:
  - N·(SETTLE+2)+1 cycles in general.
  - 57 for mode 0 or 1 with SETTLE=2.
  - 513 for mode 2 with SETTLE=2.
  - 1 for mode 3.
- led_in is sampled on the CHECK clock edge, SETTLE+1 edges after pat_out changes.
- err_count cannot overflow: the maximum is 128 patterns.
- Result outputs hold until the next accepted start.

## Structure
- Shared package or_bank_pkg holds:
  - the FSM state enum;
  - the mode encodings (MODE_WALK1, MODE_WALK0, MODE_SWEEP, MODE_NULL);
  - pattern counts (14, 14, 128);
  - the FAIL_NONE=8'hFF constant.
- One sub-module, or_bank_expect: combinational. Inputs are pat, shadow and shadow_valid. Outputs are the expected vector and the compare mask.
- The FSM, pattern generator and counters live in the top.

## Test plan
- Mode 0, SETTLE=2, real OR bank attached: done 57 cycles after start, err_count=0, fail_idx=8'hFF, bit 7 masked for the whole run.
- Mode 0 with led_in[3] forced 0: err_count=2, fail_idx=6, first_fail_led=8'h00 (expected 8'h08).
- Mode 1 with led_in[7] forced 1: err_count=1, fail_idx=13, because idx 13 clears pat[13] with pat[0]&pat[1]=1, so the shadow is 0.
- Mode 2 with led_in forced 8'h00: err_count=127, fail_idx=1, first_fail_led=8'h00; pat_out=14'h0081 at idx 1.
- rst_n asserted during SETTLE of idx 5:
  - busy=0, pat_out=0 and fail_idx=FF immediately.
  - A following mode-0 start runs the full 57 cycles from idx 0.
- Mode 3 start: done the cycle after start, err_count=0. A start pulsed mid-run in mode 0 is ignored and the run length is unchanged.
